// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Data-memory responder for the MEM stage. Services byte-strobed
//             loads/stores from an internal word RAM after programmable wait
//             states, holding the pipeline with stall until done.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] resp_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        stall
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_count;
    logic [3:0]          w_nextCount;
    logic                w_accept;

    logic [ADDR_W-1:0]   r_idx;
    logic [3:0]          r_wen;
    logic [31:0]         r_wdata;
    logic                r_err;

    logic [31:0]         r_mem [c_DEPTH];
    logic [31:0]         w_oldWord;
    logic [31:0]         w_mergedWord;
    logic                w_isStore;
    logic                w_legal;
    logic                w_doWrite;

    // Byte offset and alias bits above the RAM span carry no meaning here.
    logic                w_unusedAddrBits;
    assign w_unusedAddrBits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // Only naturally aligned byte, halfword and word strobes are accepted.
    always_comb begin
        w_legal = 1'b0;
        case (r_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    assign w_isStore = |r_wen;
    assign w_oldWord = r_mem[r_idx];
    assign w_doWrite = (r_state == S_ACCESS) && w_isStore && w_legal;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign w_mergedWord[8*i +: 8] = r_wen[i] ? r_wdata[8*i +: 8]
                                                     : w_oldWord[8*i +: 8];
        end
    endgenerate

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_accept    = 1'b0;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = req_en;
                if (req_en) begin
                    w_accept = 1'b1;
                    if (c_WAIT != 4'd0) begin
                        w_nextState = S_WAIT;
                        w_nextCount = c_WAIT;
                    end else begin
                        w_nextState = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                stall       = 1'b1;
                w_nextCount = r_count - 4'd1;
                if (r_count <= 4'd1) begin
                    w_nextState = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall       = 1'b1;
                w_nextState = S_DONE;
            end
            S_DONE: begin
                // A request still asserted here belongs to the finished access.
                resp_valid  = 1'b1;
                resp_err    = r_err;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_idx      <= '0;
            r_wen      <= 4'd0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_accept) begin
                r_idx   <= req_addr[ADDR_W+1:2];
                r_wen   <= req_wen;
                r_wdata <= req_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_err      <= w_isStore && !w_legal;
                resp_rdata <= w_doWrite ? w_mergedWord : w_oldWord;
            end
        end
    end

    // RAM is not reset; an async reset forces IDLE so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_idx] <= w_mergedWord;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder with a word-level memory
//             model; one DUT with two wait states, one with none.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        enA, enB;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [31:0] rdA, rdB;
    logic        vA, vB, eA, eB, sA, sB;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT_A)) dutA (
        .clk(clk), .rst(rst), .req_en(enA), .req_wen(wen), .req_addr(addr),
        .req_wdata(wdata), .resp_rdata(rdA), .resp_valid(vA), .resp_err(eA),
        .stall(sA)
    );

    dmem_responder #(.ADDR_W(4), .WAIT_CYCLES(WAIT_B)) dutB (
        .clk(clk), .rst(rst), .req_en(enB), .req_wen(wen), .req_addr(addr),
        .req_wdata(wdata), .resp_rdata(rdB), .resp_valid(vB), .resp_err(eB),
        .stall(sB)
    );

    function automatic bit isLegal(input logic [3:0] w);
        return w inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, d, input logic [3:0] w);
        logic [31:0] m;
        m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // Issues one request and reports response data, latency and stall cycles.
    task automatic doAccess(input bit sel, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input bit hold,
                            output logic [31:0] rd, output logic er,
                            output int lat, output int stc);
        @(posedge clk); #1;
        wen = w; addr = a; wdata = d;
        if (sel) enB = 1'b1; else enA = 1'b1;
        lat = -1; stc = 0; rd = 'x; er = 1'bx;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if ((sel ? sB : sA) === 1'b1) stc++;
            if ((sel ? vB : vA) === 1'b1) begin
                lat = k; rd = sel ? rdB : rdA; er = sel ? eB : eA;
            end
            @(posedge clk); #1;
            if (!hold || lat >= 0) begin enA = 1'b0; enB = 1'b0; end
            if (!hold) begin wen = 4'($urandom); addr = $urandom; wdata = $urandom; end
        end
    endtask

    task automatic test_reset;
        total++; if (sA !== 1'b0) begin bad++; $display("FAIL reset_stallA got=%b exp=0", sA); end
        total++; if (vA !== 1'b0) begin bad++; $display("FAIL reset_validA got=%b exp=0", vA); end
        total++; if (eA !== 1'b0) begin bad++; $display("FAIL reset_errA got=%b exp=0", eA); end
        total++; if (rdA !== 32'd0) begin bad++; $display("FAIL reset_rdataA got=%h exp=0", rdA); end
        total++; if (vB !== 1'b0) begin bad++; $display("FAIL reset_validB got=%b exp=0", vB); end
        total++; if (rdB !== 32'd0) begin bad++; $display("FAIL reset_rdataB got=%h exp=0", rdB); end
    endtask

    task automatic test_directed;
        logic [31:0] rd; logic er; int lat, stc;
        doAccess(0, 4'hF, 32'h10, 32'hDEADBEEF, 1, rd, er, lat, stc);
        model[4] = 32'hDEADBEEF;
        total++; if (lat != WAIT_A + 2) begin bad++; $display("FAIL full_store_lat got=%0d exp=%0d", lat, WAIT_A + 2); end
        total++; if (stc != WAIT_A + 2) begin bad++; $display("FAIL full_store_stall got=%0d exp=%0d", stc, WAIT_A + 2); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL full_store_rdata got=%h exp=deadbeef", rd); end
        @(negedge clk);
        total++; if (vA !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got=%b exp=0", vA); end

        doAccess(0, 4'h1, 32'h10, 32'h000000AA, 1, rd, er, lat, stc);
        model[4] = 32'hDEADBEAA;
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL byte_store_rdata got=%h exp=deadbeaa", rd); end
        doAccess(0, 4'h0, 32'h10, 32'h0, 1, rd, er, lat, stc);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL byte_load got=%h exp=deadbeaa", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL byte_load_err got=%b exp=0", er); end

        doAccess(0, 4'b0110, 32'h10, 32'h55555555, 1, rd, er, lat, stc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", er); end
        total++; if (lat != WAIT_A + 2) begin bad++; $display("FAIL illegal_lat got=%0d exp=%0d", lat, WAIT_A + 2); end
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL illegal_rdata got=%h exp=deadbeaa", rd); end
        doAccess(0, 4'h0, 32'h10, 32'h0, 1, rd, er, lat, stc);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL after_illegal_load got=%h exp=deadbeaa", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL after_illegal_err got=%b exp=0", er); end

        doAccess(0, 4'h0, 32'h10 + 32'h1000, 32'h0, 1, rd, er, lat, stc);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL alias_load got=%h exp=deadbeaa", rd); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd; logic er; int lat, stc;
        doAccess(1, 4'hF, 32'h8, 32'h11223344, 1, rd, er, lat, stc);
        total++; if (lat != WAIT_B + 2) begin bad++; $display("FAIL zw_store_lat got=%0d exp=%0d", lat, WAIT_B + 2); end
        doAccess(1, 4'h0, 32'h8, 32'h0, 0, rd, er, lat, stc);
        total++; if (lat != WAIT_B + 2) begin bad++; $display("FAIL zw_load_lat got=%0d exp=%0d", lat, WAIT_B + 2); end
        total++; if (stc != WAIT_B + 2) begin bad++; $display("FAIL zw_load_stall got=%0d exp=%0d", stc, WAIT_B + 2); end
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL zw_load_rdata got=%h exp=11223344", rd); end
    endtask

    task automatic test_drop_req;
        logic [31:0] rd; logic er; int lat, stc;
        doAccess(0, 4'hF, 32'h30, 32'h0BADF00D, 0, rd, er, lat, stc);
        model[12] = 32'h0BADF00D;
        doAccess(0, 4'h0, 32'h30, 32'h0, 0, rd, er, lat, stc);
        total++; if (lat != WAIT_A + 2) begin bad++; $display("FAIL drop_lat got=%0d exp=%0d", lat, WAIT_A + 2); end
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL drop_rdata got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat, stc; bit sawValid;
        doAccess(0, 4'hF, 32'h20, 32'hCAFEF00D, 1, rd, er, lat, stc);
        model[8] = 32'hCAFEF00D;
        @(posedge clk); #1;
        wen = 4'hF; addr = 32'h20; wdata = 32'h12345678; enA = 1'b1;
        @(posedge clk); #1;
        enA = 1'b0;
        @(negedge clk);
        total++; if (sA !== 1'b1) begin bad++; $display("FAIL mid_wait_stall got=%b exp=1", sA); end
        rst = 1'b1;
        #1;
        total++; if (sA !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%b exp=0", sA); end
        total++; if (vA !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", vA); end
        total++; if (rdA !== 32'd0) begin bad++; $display("FAIL mid_rst_rdata got=%h exp=0", rdA); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (8) begin @(negedge clk); if (vA === 1'b1) sawValid = 1'b1; end
        total++; if (sawValid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_valid got=%b exp=0", sawValid); end
        doAccess(0, 4'h0, 32'h20, 32'h0, 1, rd, er, lat, stc);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_rst_old_word got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, expRd; logic er, expErr; logic [3:0] w;
        int lat, stc, idx;
        int idxs[8];
        for (int i = 0; i < 8; i++) begin
            idxs[i] = $urandom_range(16, 1023);
            d = $urandom;
            doAccess(0, 4'hF, 32'(idxs[i]) << 2, d, 1, rd, er, lat, stc);
            model[idxs[i]] = d;
            total++; if (rd !== d) begin bad++; $display("FAIL rnd_init_rdata idx=%0d got=%h exp=%h", idxs[i], rd, d); end
        end
        for (int n = 0; n < 40; n++) begin
            idx = idxs[$urandom_range(0, 7)];
            a = (32'($urandom) << 12) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            if (w == 4'h0) begin
                expRd = model[idx]; expErr = 1'b0;
            end else if (isLegal(w)) begin
                expRd = mergeWord(model[idx], d, w); model[idx] = expRd; expErr = 1'b0;
            end else begin
                expRd = model[idx]; expErr = 1'b1;
            end
            doAccess(0, w, a, d, 1'($urandom_range(0, 1)), rd, er, lat, stc);
            total++; if (lat != WAIT_A + 2) begin bad++; $display("FAIL rnd_lat n=%0d got=%0d exp=%0d", n, lat, WAIT_A + 2); end
            total++; if (stc != WAIT_A + 2) begin bad++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stc, WAIT_A + 2); end
            total++; if (rd !== expRd) begin bad++; $display("FAIL rnd_rdata n=%0d wen=%b got=%h exp=%h", n, w, rd, expRd); end
            total++; if (er !== expErr) begin bad++; $display("FAIL rnd_err n=%0d wen=%b got=%b exp=%b", n, w, er, expErr); end
        end
    endtask

    initial begin
        rst = 1'b1; enA = 1'b0; enB = 1'b0;
        wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_zero_wait();
        test_drop_req();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
